// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the counter library: FSM state encodings and
// mode constants used by the countdown timer (and its up-counter sibling).
package countdown_timer_pkg;

    // FSM state encodings, 2-bit, kept as plain constants for legacy tools
    localparam logic [1:0] CT_IDLE = 2'd0;
    localparam logic [1:0] CT_RUN  = 2'd1;
    localparam logic [1:0] CT_DONE = 2'd2;

    // Mode select values
    localparam logic CT_ONESHOT  = 1'b0;
    localparam logic CT_PERIODIC = 1'b1;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with a one-cycle terminal-count pulse. Counts down
// on enabled clocks while in RUN; on expiry either stops in DONE (one-shot)
// or reloads the last loaded value and keeps running (periodic).
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clock_i,
    input  logic             reset_ni,
    input  logic             enable_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    input  logic             mode_i,
    output logic [WIDTH-1:0] out_o,
    output logic             tc_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = '0;

    logic [WIDTH-1:0] count_q,  count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [1:0]       state_q,  state_d;
    logic             tc_q,     tc_d;

    // Next-state logic: load beats enable; tc defaults low so it is a single-cycle pulse
    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        state_d  = state_q;
        tc_d     = 1'b0;
        if (load_i) begin
            reload_d = load_value_i;
            count_d  = load_value_i;
            // Loading zero would have nothing to count, so park in IDLE
            state_d  = (load_value_i != ZERO) ? CT_RUN : CT_IDLE;
        end else if (enable_i && (state_q == CT_RUN)) begin
            if (count_q > ONE) begin
                count_d = count_q - ONE;
            end else if (count_q == ONE) begin
                // Terminal edge: mode is only looked at here
                tc_d = 1'b1;
                if (mode_i == CT_PERIODIC) begin
                    count_d = reload_q;
                end else begin
                    count_d = ZERO;
                    state_d = CT_DONE;
                end
            end
            // count_q == 0 in RUN is unreachable; holding avoids any underflow
        end
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            count_q  <= ZERO;
            reload_q <= ZERO;
            state_q  <= CT_IDLE;
            tc_q     <= 1'b0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            state_q  <= state_d;
            tc_q     <= tc_d;
        end
    end

    assign out_o  = count_q;
    assign tc_o   = tc_q;
    assign busy_o = (state_q == CT_RUN);
    assign done_o = (state_q == CT_DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: table of per-edge vectors fed
// through a scoreboard queue, plus a hand-written async-reset sequence.
module tb_countdown_timer;

    logic       clock;
    logic       reset_n;
    logic       enable;
    logic       load;
    logic [3:0] load_value;
    logic       mode;
    logic [3:0] out;
    logic       tc;
    logic       busy;
    logic       done;

    countdown_timer #(.WIDTH(4)) dut (
        .clock_i      (clock),
        .reset_ni     (reset_n),
        .enable_i     (enable),
        .load_i       (load),
        .load_value_i (load_value),
        .mode_i       (mode),
        .out_o        (out),
        .tc_o         (tc),
        .busy_o       (busy),
        .done_o       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       ld;
        logic [3:0] lv;
        logic       md;
        logic       en;
        logic [3:0] e_out;
        logic       e_tc;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    typedef struct {
        int         idx;
        logic [3:0] e_out;
        logic       e_tc;
        logic       e_busy;
        logic       e_done;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;
    int   tc_pulses = 0;

    task automatic add(input logic ld, input logic [3:0] lv, input logic md,
                       input logic en, input logic [3:0] e_out, input logic e_tc,
                       input logic e_busy, input logic e_done);
        vec_t v;
        v.ld = ld; v.lv = lv; v.md = md; v.en = en;
        v.e_out = e_out; v.e_tc = e_tc; v.e_busy = e_busy; v.e_done = e_done;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [3:0] act,
                         input logic [3:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s vec=%0d got=%0d expected=%0d", name, idx, act, req);
    endtask

    // Drive one vector at the falling edge, score it 1 time unit after the rising edge
    task automatic apply(input int idx, input vec_t v);
        exp_t e;
        exp_t g;
        load = v.ld; load_value = v.lv; mode = v.md; enable = v.en;
        e.idx = idx; e.e_out = v.e_out; e.e_tc = v.e_tc;
        e.e_busy = v.e_busy; e.e_done = v.e_done;
        sb.push_back(e);
        @(posedge clock);
        #1;
        g = sb.pop_front();
        if (tc === 1'b1) tc_pulses++;
        $display("vec %0d ld=%0d lv=%0d md=%0d en=%0d -> out=%0d tc=%0d busy=%0d done=%0d",
                 g.idx, v.ld, v.lv, v.md, v.en, out, tc, busy, done);
        check("out",  g.idx, out,          g.e_out);
        check("tc",   g.idx, {3'b0, tc},   {3'b0, g.e_tc});
        check("busy", g.idx, {3'b0, busy}, {3'b0, g.e_busy});
        check("done", g.idx, {3'b0, done}, {3'b0, g.e_done});
        @(negedge clock);
    endtask

    task automatic run_from(input int first);
        for (int i = first; i < vecs.size(); i++) apply(i, vecs[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset_n = 1'b0; enable = 1'b0; load = 1'b0; load_value = 4'd0; mode = 1'b0;

        // Idle after reset: enable toggling must not move anything
        for (int i = 0; i < 4; i++) add(0, 0, 0, i[0], 0, 0, 0, 0);
        // One-shot load 5: 5,4,3,2,1,0 with tc on the 0 cycle, then hold in DONE
        add(1, 5, 0, 1, 5, 0, 1, 0);
        for (int n = 4; n >= 1; n--) add(0, 0, 0, 1, 4'(n), 0, 1, 0);
        add(0, 0, 0, 1, 0, 1, 0, 1);
        add(0, 0, 0, 1, 0, 0, 0, 1);
        add(0, 0, 0, 1, 0, 0, 0, 1);
        // Full range 15 one-shot: 15 enabled edges to tc, no wrap afterwards
        add(1, 15, 0, 1, 15, 0, 1, 0);
        for (int n = 14; n >= 1; n--) add(0, 0, 0, 1, 4'(n), 0, 1, 0);
        add(0, 0, 0, 1, 0, 1, 0, 1);
        add(0, 0, 0, 1, 0, 0, 0, 1);
        // Periodic load 3 for 12 enabled edges: 2,1,3(tc) x4
        add(1, 3, 1, 1, 3, 0, 1, 0);
        for (int k = 0; k < 4; k++) begin
            add(0, 0, 1, 1, 2, 0, 1, 0);
            add(0, 0, 1, 1, 1, 0, 1, 0);
            add(0, 0, 1, 1, 3, 1, 1, 0);
        end
        // Two disabled cycles stretch the period; tc drops while disabled
        add(0, 0, 1, 0, 3, 0, 1, 0);
        add(0, 0, 1, 0, 3, 0, 1, 0);
        add(0, 0, 1, 1, 2, 0, 1, 0);
        add(0, 0, 1, 1, 1, 0, 1, 0);
        add(0, 0, 1, 1, 3, 1, 1, 0);
        // Load on the terminal edge wins: no tc, new value taken
        add(1, 4, 0, 1, 4, 0, 1, 0);
        add(0, 0, 0, 1, 3, 0, 1, 0);
        add(0, 0, 0, 1, 2, 0, 1, 0);
        add(0, 0, 0, 1, 1, 0, 1, 0);
        add(1, 9, 0, 1, 9, 0, 1, 0);
        add(0, 0, 0, 1, 8, 0, 1, 0);
        // Load 0 parks in IDLE and enable is then ignored
        add(1, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0);
        // Periodic reload 1: tc on every enabled edge, out never 0
        add(1, 1, 1, 0, 1, 0, 1, 0);
        add(0, 0, 1, 1, 1, 1, 1, 0);
        add(0, 0, 1, 1, 1, 1, 1, 0);
        // Mode switched to one-shot mid-run applies at the expiry
        add(1, 2, 1, 1, 2, 0, 1, 0);
        add(0, 0, 0, 1, 1, 0, 1, 0);
        add(0, 0, 0, 1, 0, 1, 0, 1);
        base = vecs.size();
        // Run to 7 before the async reset sequence
        add(1, 9, 0, 1, 9, 0, 1, 0);
        add(0, 0, 0, 1, 8, 0, 1, 0);
        add(0, 0, 0, 1, 7, 0, 1, 0);

        // Reset state while reset is held
        #50;
        check("rst_out",  -1, out,          4'd0);
        check("rst_tc",   -1, {3'b0, tc},   4'd0);
        check("rst_busy", -1, {3'b0, busy}, 4'd0);
        check("rst_done", -1, {3'b0, done}, 4'd0);
        #50;
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < base; i++) apply(i, vecs[i]);
        run_from(base);

        // Count periodic tc pulses as a sanity total: 4+1 (load-3 run) +2 (reload 1)
        // plus one-shot pulses 1+1+1 (load 5, load 15, mode switch) = 10
        check("tc_pulses", -2, 4'(tc_pulses), 4'd10);

        // Async reset between edges clears outputs without a clock edge
        #2;
        reset_n = 1'b0;
        #1;
        $display("async reset asserted -> out=%0d tc=%0d busy=%0d done=%0d", out, tc, busy, done);
        check("arst_out",  -3, out,          4'd0);
        check("arst_busy", -3, {3'b0, busy}, 4'd0);
        check("arst_done", -3, {3'b0, done}, 4'd0);
        check("arst_tc",   -3, {3'b0, tc},   4'd0);
        @(negedge clock);
        reset_n = 1'b1;
        begin
            vec_t v;
            v.ld = 0; v.lv = 0; v.md = 0; v.en = 1;
            v.e_out = 0; v.e_tc = 0; v.e_busy = 0; v.e_done = 0;
            for (int i = 0; i < 3; i++) apply(1000 + i, v);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
